// File: rtl/nco_phase_tracker.sv
// Sequential CORDIC vectoring phase tracker: recovers phase and per-sample phase
// increment from sin/cos pairs. Define NCO_PHASE_TRACKER_AVG_EN to average the last 4 increments.
module nco_phase_tracker #(
  parameter int IN_W = 12,
  parameter int PH_W = 32,
  parameter int ITER = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            in_valid,
  input  logic [IN_W-1:0] sin_i,
  input  logic [IN_W-1:0] cos_i,
  output logic            busy,
  output logic            overrun,
  output logic            out_valid,
  output logic [PH_W-1:0] phase_o,
  output logic [PH_W-1:0] phi_inc_o,
  output logic            inc_valid
);
  localparam int XW = IN_W + 2;
  localparam int CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  // atan(2^-i) in turns, 32-bit full scale, rescaled with rounding to PH_W
  function automatic logic [PH_W-1:0] f_atan(input logic [CW-1:0] i);
    logic [31:0] a;
    logic [63:0] t;
    case (i)
      5'd0:    a = 32'h20000000;
      5'd1:    a = 32'h12E4051E;
      5'd2:    a = 32'h09FB385B;
      5'd3:    a = 32'h051111D4;
      5'd4:    a = 32'h028B0D43;
      5'd5:    a = 32'h0145D7E1;
      5'd6:    a = 32'h00A2F61E;
      5'd7:    a = 32'h00517C55;
      5'd8:    a = 32'h0028BE53;
      5'd9:    a = 32'h00145F2F;
      5'd10:   a = 32'h000A2F98;
      5'd11:   a = 32'h000517CC;
      5'd12:   a = 32'h00028BE6;
      5'd13:   a = 32'h000145F3;
      5'd14:   a = 32'h0000A2FA;
      5'd15:   a = 32'h0000517D;
      default: a = 32'h0;
    endcase
    t = {a, 32'h0};
    return PH_W'((t + (64'd1 << (63 - PH_W))) >> (64 - PH_W));
  endfunction

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_i;
  logic signed [XW-1:0]   r_x, r_y;
  logic signed [XW-1:0]   w_xs, w_ys, w_sin, w_cos;
  logic [PH_W-1:0]        r_z, r_prev;
  logic                   r_prev_vld, r_zero;
  logic [PH_W-1:0]        w_ang, w_zf, w_diff, w_inc;
  logic                   w_incv;

  assign w_sin  = {{2{sin_i[IN_W-1]}}, sin_i};
  assign w_cos  = {{2{cos_i[IN_W-1]}}, cos_i};
  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;
  assign w_ang  = f_atan(r_i);
  // an all-zero input has no angle; report 0 rather than the CORDIC's drift
  assign w_zf   = r_zero ? '0 : r_z;
  assign w_diff = w_zf - r_prev;
  assign busy   = (r_state != S_IDLE);

`ifdef NCO_PHASE_TRACKER_AVG_EN
  logic [PH_W-1:0]        r_h0, r_h1, r_h2;
  logic [1:0]             r_dcnt;
  logic signed [PH_W+1:0] w_sum;

  assign w_sum  = $signed({{2{w_diff[PH_W-1]}}, w_diff}) + $signed({{2{r_h0[PH_W-1]}}, r_h0})
                + $signed({{2{r_h1[PH_W-1]}}, r_h1}) + $signed({{2{r_h2[PH_W-1]}}, r_h2});
  assign w_inc  = w_sum[PH_W+1:2];
  assign w_incv = r_prev_vld && (r_dcnt == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h0   <= '0;
      r_h1   <= '0;
      r_h2   <= '0;
      r_dcnt <= '0;
    end else if (clken && r_state == S_DONE && r_prev_vld) begin
      r_h0 <= w_diff;
      r_h1 <= r_h0;
      r_h2 <= r_h1;
      if (r_dcnt != 2'd3) r_dcnt <= r_dcnt + 2'd1;
    end
  end
`else
  assign w_inc  = w_diff;
  assign w_incv = r_prev_vld;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ITER;
      S_ITER:  if (r_i == CW'(ITER - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else if (clken) r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_i        <= '0;
      r_zero     <= 1'b0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      phase_o    <= '0;
      phi_inc_o  <= '0;
      inc_valid  <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else if (clken) begin
      out_valid <= 1'b0;
      overrun   <= in_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_i    <= '0;
          r_zero <= (sin_i == '0) && (cos_i == '0);
          // fold left half-plane into the right half; XW leaves room for -(-2^(IN_W-1))
          if (cos_i[IN_W-1]) begin
            r_x <= -w_cos;
            r_y <= -w_sin;
            r_z <= {1'b1, {(PH_W-1){1'b0}}};
          end else begin
            r_x <= w_cos;
            r_y <= w_sin;
            r_z <= '0;
          end
        end
        S_ITER: begin
          r_i <= r_i + CW'(1);
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_ang;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_ang;
          end
        end
        S_DONE: begin
          phase_o    <= w_zf;
          phi_inc_o  <= w_inc;
          inc_valid  <= w_incv;
          r_prev     <= w_zf;
          r_prev_vld <= 1'b1;
          out_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_phase_tracker.sv
// Self-checking bench for nco_phase_tracker: floating-point atan2 reference with
// a phase-history model for the increment output.
module tb_nco_phase_tracker;
  localparam int    IN_W = 12;
  localparam int    PH_W = 32;
  localparam int    ITER = 14;
  localparam int    LAT  = ITER + 1;
  localparam real   PI   = 3.14159265358979;
  localparam longint M   = 64'h1_0000_0000;
  localparam longint H   = 64'h0_8000_0000;

  logic            clk = 1'b0, reset_n = 1'b0, clken = 1'b1, in_valid = 1'b0;
  logic [IN_W-1:0] sin_i = '0, cos_i = '0;
  logic            busy, overrun, out_valid, inc_valid;
  logic [PH_W-1:0] phase_o, phi_inc_o;

  nco_phase_tracker #(.IN_W(IN_W), .PH_W(PH_W), .ITER(ITER)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .in_valid(in_valid),
    .sin_i(sin_i), .cos_i(cos_i), .busy(busy), .overrun(overrun),
    .out_valid(out_valid), .phase_o(phase_o), .phi_inc_o(phi_inc_o), .inc_valid(inc_valid)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  real theta = 0.0;

  // reference model state
  bit      m_have = 0;
  longint  m_prev = 0;
  longint  m_q[$];
  longint  e_phase, e_inc;
  bit      e_incv;

  // observations
  int              o_lat, o_ovc;
  logic [PH_W-1:0] o_phase, o_inc;
  logic            o_incv, o_busy1, o_busy_end;

  function automatic longint ref_phase(input int s, input int c);
    real a;
    if (s == 0 && c == 0) return 0;
    a = $atan2(real'(s), real'(c)) / (2.0 * PI);
    if (a < 0.0) a = a + 1.0;
    return longint'(a * real'(M)) % M;
  endfunction

  function automatic longint wd(input logic [31:0] a, input longint b);
    longint d;
    d = (longint'(a) - b) & (M - 1);
    if (d >= H) d = M - d;
    return d;
  endfunction

  task automatic sample_at(input real t, input real amp, output int s, output int c);
    s = int'(amp * $sin(2.0 * PI * t));
    c = int'(amp * $cos(2.0 * PI * t));
  endtask

  task automatic model_clear();
    m_have = 0; m_prev = 0; m_q.delete();
  endtask

  task automatic model_push(input longint r);
    longint d, sum;
    e_phase = r;
    d = (r - m_prev) & (M - 1);
    e_inc = d;
    if (m_have) begin
      if (d >= H) d = d - M;
      m_q.push_back(d);
      if (m_q.size() > 4) void'(m_q.pop_front());
    end
`ifdef NCO_PHASE_TRACKER_AVG_EN
    sum = 0;
    foreach (m_q[j]) sum = sum + m_q[j];
    e_inc  = (sum >>> 2) & (M - 1);
    e_incv = (m_q.size() == 4);
`else
    e_incv = m_have;
`endif
    m_have = 1; m_prev = r;
  endtask

  // Caller must be at a negedge; returns at the negedge after out_valid (or timeout).
  task automatic do_sample(input int s, input int c, input int stall_at, input int stall_len,
                           input int ov_at);
    int ns, nc;
    sin_i = s[IN_W-1:0]; cos_i = c[IN_W-1:0]; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; o_busy1 = busy; o_ovc = 0; o_lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == stall_at) clken = 1'b0;
      if (n == stall_at + stall_len) clken = 1'b1;
      if (n == ov_at) begin
        ns = -s; nc = -c;
        sin_i = ns[IN_W-1:0]; cos_i = nc[IN_W-1:0]; in_valid = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      if (overrun) o_ovc++;
      if (out_valid) begin o_lat = n; break; end
    end
    clken = 1'b1;
    o_phase = phase_o; o_inc = phi_inc_o; o_incv = inc_valid; o_busy_end = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom); sin_i = IN_W'($urandom); cos_i = IN_W'($urandom);
    end
    #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset overrun got=%b exp=0", overrun); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    checks++; if (inc_valid !== 1'b0) begin errs++; $display("FAIL reset inc_valid got=%b exp=0", inc_valid); end
    checks++; if (phase_o !== '0) begin errs++; $display("FAIL reset phase_o got=%h exp=0", phase_o); end
    checks++; if (phi_inc_o !== '0) begin errs++; $display("FAIL reset phi_inc_o got=%h exp=0", phi_inc_o); end
    @(negedge clk);
    in_valid = 1'b0; reset_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_quadrants();
    int s, c;
    for (int q = 0; q < 4; q++) begin
      theta = 0.25 * q;
      sample_at(theta, 2047.0, s, c);
      do_sample(s, c, 0, 0, 0);
      model_push(ref_phase(s, c));
      checks++; if (o_lat != LAT) begin errs++; $display("FAIL quad%0d latency got=%0d exp=%0d", q, o_lat, LAT); end
      checks++; if (wd(o_phase, e_phase) > (64'd1 << 20)) begin errs++; $display("FAIL quad%0d phase got=%h exp=%h", q, o_phase, e_phase); end
      checks++; if (o_incv !== e_incv) begin errs++; $display("FAIL quad%0d inc_valid got=%b exp=%b", q, o_incv, e_incv); end
      checks++; if (o_busy1 !== 1'b1 || o_busy_end !== 1'b0) begin errs++; $display("FAIL quad%0d busy got=%b/%b exp=1/0", q, o_busy1, o_busy_end); end
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL quad%0d out_valid_drop got=%b exp=0", q, out_valid); end
    end
  endtask

  task automatic test_nco_stream();
    int s, c;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    model_clear();
    theta = 0.0;
    for (int k = 0; k < 8; k++) begin
      sample_at(theta, 2047.0, s, c);
      do_sample(s, c, 0, 0, 0);
      model_push(ref_phase(s, c));
      checks++; if (o_incv !== e_incv) begin errs++; $display("FAIL stream%0d inc_valid got=%b exp=%b", k, o_incv, e_incv); end
      if (e_incv) begin
        checks++; if (wd(o_inc, 64'h5000_0000) > (64'd1 << 21)) begin errs++; $display("FAIL stream%0d phi_inc got=%h exp=50000000", k, o_inc); end
      end
      checks++; if (wd(o_phase, e_phase) > (64'd1 << 21)) begin errs++; $display("FAIL stream%0d phase got=%h exp=%h", k, o_phase, e_phase); end
      theta = theta + 0.3125;
    end
  endtask

  task automatic test_random();
    int s, c;
    real amp;
    for (int k = 0; k < 10; k++) begin
      theta = theta + 0.35 * (real'($urandom_range(0, 2000)) - 1000.0) / 1000.0;
      amp = 1536.0 + real'($urandom_range(0, 511));
      sample_at(theta, amp, s, c);
      do_sample(s, c, 0, 0, 0);
      model_push(ref_phase(s, c));
      checks++; if (o_lat != LAT) begin errs++; $display("FAIL rand%0d latency got=%0d exp=%0d", k, o_lat, LAT); end
      checks++; if (wd(o_phase, e_phase) > (64'd1 << 21)) begin errs++; $display("FAIL rand%0d phase got=%h exp=%h", k, o_phase, e_phase); end
      checks++; if (o_incv !== e_incv) begin errs++; $display("FAIL rand%0d inc_valid got=%b exp=%b", k, o_incv, e_incv); end
      if (e_incv) begin
        checks++; if (wd(o_inc, e_inc) > (64'd1 << 22)) begin errs++; $display("FAIL rand%0d phi_inc got=%h exp=%h", k, o_inc, e_inc); end
      end
    end
  endtask

  task automatic test_overrun();
    int s, c, nov, nout;
    theta = theta + 0.2;
    sample_at(theta, 2047.0, s, c);
    do_sample(s, c, 0, 0, 3);
    model_push(ref_phase(s, c));
    checks++; if (o_ovc != 1) begin errs++; $display("FAIL overrun pulses got=%0d exp=1", o_ovc); end
    checks++; if (o_lat != LAT) begin errs++; $display("FAIL overrun latency got=%0d exp=%0d", o_lat, LAT); end
    checks++; if (wd(o_phase, e_phase) > (64'd1 << 21)) begin errs++; $display("FAIL overrun phase got=%h exp=%h", o_phase, e_phase); end
    nov = 0; nout = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (overrun) nov++;
      if (out_valid) nout++;
    end
    checks++; if (nout != 0) begin errs++; $display("FAIL overrun extra_out_valid got=%0d exp=0", nout); end
    checks++; if (nov != 0) begin errs++; $display("FAIL overrun extra_pulse got=%0d exp=0", nov); end
  endtask

  task automatic test_clken_stall();
    int s, c;
    theta = theta + 0.15;
    sample_at(theta, 2047.0, s, c);
    do_sample(s, c, 5, 5, 0);
    model_push(ref_phase(s, c));
    checks++; if (o_lat != LAT + 5) begin errs++; $display("FAIL stall latency got=%0d exp=%0d", o_lat, LAT + 5); end
    checks++; if (wd(o_phase, e_phase) > (64'd1 << 21)) begin errs++; $display("FAIL stall phase got=%h exp=%h", o_phase, e_phase); end
    checks++; if (o_incv !== e_incv) begin errs++; $display("FAIL stall inc_valid got=%b exp=%b", o_incv, e_incv); end
  endtask

  task automatic test_reset_mid();
    int s, c, nout;
    theta = theta + 0.1;
    sample_at(theta, 2047.0, s, c);
    sin_i = s[IN_W-1:0]; cos_i = c[IN_W-1:0]; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); reset_n = 1'b0; #1;
    checks++; if (phase_o !== '0 || phi_inc_o !== '0) begin errs++; $display("FAIL rstmid data got=%h/%h exp=0/0", phase_o, phi_inc_o); end
    checks++; if (busy !== 1'b0 || inc_valid !== 1'b0) begin errs++; $display("FAIL rstmid flags got=%b/%b exp=0/0", busy, inc_valid); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    nout = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) nout++;
    end
    checks++; if (nout != 0) begin errs++; $display("FAIL rstmid stale_result got=%0d exp=0", nout); end
    theta = 0.1;
    sample_at(theta, 2047.0, s, c);
    do_sample(s, c, 0, 0, 0);
    model_push(ref_phase(s, c));
    checks++; if (o_incv !== 1'b0) begin errs++; $display("FAIL rstmid first_inc_valid got=%b exp=0", o_incv); end
    checks++; if (wd(o_phase, e_phase) > (64'd1 << 21)) begin errs++; $display("FAIL rstmid phase got=%h exp=%h", o_phase, e_phase); end
  endtask

  task automatic test_zero();
    do_sample(0, 0, 0, 0, 0);
    model_push(ref_phase(0, 0));
    checks++; if (o_phase !== '0) begin errs++; $display("FAIL zero phase got=%h exp=0", o_phase); end
    checks++; if (o_incv !== e_incv) begin errs++; $display("FAIL zero inc_valid got=%b exp=%b", o_incv, e_incv); end
    if (e_incv) begin
      checks++; if (wd(o_inc, e_inc) > (64'd1 << 22)) begin errs++; $display("FAIL zero phi_inc got=%h exp=%h", o_inc, e_inc); end
    end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_nco_stream();
    test_random();
    test_overrun();
    test_clken_stall();
    test_reset_mid();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/nco_phase_tracker.md
# nco_phase_tracker

Recovers instantaneous phase and phase increment from a stream of signed sin/cos sample pairs, i.e. the inverse of the NCO: NCO output pairs go in, a phase word and a `phi_inc`-format frequency word come out. It is used in DDC loopback checking and carrier tracking. Each accepted pair is processed by a sequential CORDIC vectoring engine, and the result is differenced against the previous phase.

## Interface
Parameters:
- `IN_W`, default 12: sample width, two's complement.
- `PH_W`, default 32: phase and increment width; full scale is 2^PH_W per cycle.
- `ITER`, default 14: CORDIC iterations, range 8..16.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clken`, in, 1: clock enable; low freezes every register.
- `in_valid`, in, 1: the sample pair is present.
- `sin_i`, in, `IN_W`: signed sine (quadrature) sample.
- `cos_i`, in, `IN_W`: signed cosine (in-phase) sample.
- `busy`, out, 1: high when state ≠ IDLE.
- `overrun`, out, 1: one-cycle pulse; a sample was dropped.
- `out_valid`, out, 1: one-cycle result strobe.
- `phase_o`, out, `PH_W`: phase, unsigned, 0x0 = 0 rad.
- `phi_inc_o`, out, `PH_W`: phase difference, modulo 2^PH_W.
- `inc_valid`, out, 1: `phi_inc_o` is meaningful.

## Operation
- All outputs reset to 0; state resets to IDLE; the previous-phase register is cleared and marked empty.
- Every action below requires `clken` = 1.
- **IDLE:**
  - An edge with `in_valid` accepts the sample and pre-rotates it into x, y, z registers of width `IN_W`+2.
  - If `cos_i` < 0: x = -cos, y = -sin, z = 2^(PH_W-1). Otherwise x = cos, y = sin, z = 0.
  - -(-2^(IN_W-1)) must not overflow.
  - Go to ITER with counter i = 0.
- **ITER:**
  - Per cycle: if y ≥ 0 then x += y>>>i, y -= x>>>i, z += A[i]; else x -= y>>>i, y += x>>>i, z -= A[i].
  - Both shifts use the old x and y. z wraps modulo 2^PH_W.
  - A[i] = round(atan(2^-i)/(2π)·2^PH_W). For PH_W = 32: A[0] = 0x20000000, A[1] = 0x12E4051E, A[2] = 0x09FB385B. The table is a constant ROM.
  - After i = ITER-1, go to DONE.
- **DONE (one cycle):**
  - `phase_o` ← z.
  - `phi_inc_o` ← z − prev, wrapping.
  - `inc_valid` ← 1 if prev was non-empty, else 0. Then prev ← z.
  - `out_valid` = 1. Go to IDLE.
- `in_valid` while `busy`: the sample is dropped and `overrun` pulses for one cycle. No state is disturbed.
- Input (0,0) yields phase 0; it is legal and still updates prev.
- CORDIC gain is not corrected; magnitude is discarded.
- Accuracy: for full-scale input with ITER = 14, phase error is ≤ 2^(PH_W-12) LSB.

## Timing
- Sample accepted at edge k → `out_valid`, `phase_o` and `phi_inc_o` update at edge k+ITER+1. Latency is 15 cycles at the default ITER.
- `busy` is high from edge k+1 through edge k+ITER+1; IDLE is re-entered on that same edge.
- The earliest next acceptance is edge k+ITER+2, giving a throughput of one pair per ITER+2 enabled cycles.
- `phase_o`, `phi_inc_o` and `inc_valid` hold between strobes.
- `out_valid` and `overrun` drop after one enabled cycle. With `clken` low they hold their value.
- `clken` low stretches latency by exactly the number of disabled cycles; the result is bit-identical.
- `reset_n` low mid-operation clears all state immediately and discards the in-flight sample. The first post-reset result has `inc_valid` = 0.

## Configuration
- `NCO_PHASE_TRACKER_AVG_EN` defined:
  - `phi_inc_o` is the mean of the last 4 differences: a signed sum of 4 wrapped differences, arithmetic shift right by 2.
  - `inc_valid` rises only once 4 differences exist.
  - The history clears on reset.
- Undefined: `phi_inc_o` is the raw single difference, as described above.

## Test plan
- **Reset check:** hold `reset_n` = 0 and toggle inputs → all outputs 0, `busy` = 0.
- **Quadrants:** with `clken` = 1, present each pair in isolation (not back-to-back):
  - (sin, cos) = (0, 2047) → `phase_o` 0x00000000.
  - (2047, 0) → 0x40000000.
  - (0, -2047) → 0x80000000.
  - (-2047, 0) → 0xC0000000.
  - All within ±2^20; `out_valid` 15 cycles after acceptance.
- **NCO stream:** phase step 0x50000000, amplitude 2047, one pair every 16 cycles → first result `inc_valid` = 0; thereafter `phi_inc_o` = 0x50000000 ±2^21 and `inc_valid` = 1. With AVG_EN, `inc_valid` asserts on the 5th result.
- **Overrun:** second `in_valid` 3 cycles after acceptance → `overrun` pulses once; the result equals the first sample's; no second `out_valid`.
- **Clock enable stall:** drive `clken` = 0 for 5 cycles mid-ITER → identical `phase_o`; `out_valid` at cycle 20 instead of 15.
- **Reset mid-operation:** assert `reset_n` at iteration 6 → outputs 0 at once; the next result has `inc_valid` = 0.
